// File: rtl/bounce_sprite_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : bounce_sprite_gen
//  Brief    : Pixel colour source for the VGA timing driver. Draws a
//             rectangular sprite over a flat background and moves it once
//             per frame during vertical blanking, reflecting off the edges.
//  Revision : 1.0 - initial release
// ============================================================================
module bounce_sprite_gen #(
  parameter int          H_ACTIVE = 640,
  parameter int          V_ACTIVE = 480,
  parameter int          BOX_W    = 32,
  parameter int          BOX_H    = 32,
  parameter int          STEP     = 2,
  parameter int          INIT_X   = 304,
  parameter int          INIT_Y   = 224,
  parameter logic [7:0]  BG_COLOR = 8'h00
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [9:0]  next_x,
  input  logic [9:0]  next_y,
  input  logic        run,
  input  logic        restart,
  input  logic [7:0]  sprite_color,
  output logic [7:0]  color_out,
  output logic        frame_tick,
  output logic [9:0]  box_x,
  output logic [9:0]  box_y,
  output logic [7:0]  bounce_count
);

  // Geometry constants, all in the 11-bit domain used for position maths
  localparam logic [10:0] c_h_active = 11'(H_ACTIVE);
  localparam logic [10:0] c_v_active = 11'(V_ACTIVE);
  localparam logic [10:0] c_box_w    = 11'(BOX_W);
  localparam logic [10:0] c_box_h    = 11'(BOX_H);
  localparam logic [10:0] c_x_max    = 11'(H_ACTIVE - BOX_W);
  localparam logic [10:0] c_y_max    = 11'(V_ACTIVE - BOX_H);
  localparam logic [10:0] c_step     = 11'(STEP);
  localparam logic [9:0]  c_step_10  = 10'(STEP);
  localparam logic [9:0]  c_init_x   = 10'(INIT_X);
  localparam logic [9:0]  c_init_y   = 10'(INIT_Y);
  localparam logic [9:0]  c_x_max_10 = 10'(H_ACTIVE - BOX_W);
  localparam logic [9:0]  c_y_max_10 = 10'(V_ACTIVE - BOX_H);

  // Motion FSM encoding
  localparam logic [1:0] S_WAIT_FRAME = 2'd0;
  localparam logic [1:0] S_UPDATE_X   = 2'd1;
  localparam logic [1:0] S_UPDATE_Y   = 2'd2;

  logic [1:0]  r_state;
  logic        r_cond_d;
  logic        r_dir_x;   // 1 = moving toward larger x
  logic        r_dir_y;   // 1 = moving toward larger y

  logic        w_frame_cond;
  logic [10:0] w_x_inc;
  logic [10:0] w_y_inc;
  logic [10:0] w_px;
  logic [10:0] w_py;
  logic [10:0] w_bx;
  logic [10:0] w_by;
  logic        w_in_active;
  logic        w_in_box;

  // First blanking line begins at (0, V_ACTIVE)
  assign w_frame_cond = (next_y == c_v_active[9:0]) && (next_x == 10'd0);

  assign w_x_inc = {1'b0, box_x} + c_step;
  assign w_y_inc = {1'b0, box_y} + c_step;

  assign w_px = {1'b0, next_x};
  assign w_py = {1'b0, next_y};
  assign w_bx = {1'b0, box_x};
  assign w_by = {1'b0, box_y};

  assign w_in_active = (w_px < c_h_active) && (w_py < c_v_active);
  assign w_in_box    = (w_px >= w_bx) && (w_px < w_bx + c_box_w) &&
                       (w_py >= w_by) && (w_py < w_by + c_box_h);

  // Rising-edge detect of the blanking coordinate gives a single-cycle tick
  always_ff @(posedge clock) begin
    if (reset) begin
      r_cond_d   <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      r_cond_d   <= w_frame_cond;
      frame_tick <= w_frame_cond & ~r_cond_d;
    end
  end

  // Registered pixel path: blanked outside the active area, sprite over background
  always_ff @(posedge clock) begin
    if (reset) begin
      color_out <= 8'h00;
    end else if (!w_in_active) begin
      color_out <= 8'h00;
    end else if (w_in_box) begin
      color_out <= sprite_color;
    end else begin
      color_out <= BG_COLOR;
    end
  end

  // Motion FSM: one x step then one y step per frame tick while running
  always_ff @(posedge clock) begin
    if (reset || restart) begin
      r_state      <= S_WAIT_FRAME;
      box_x        <= c_init_x;
      box_y        <= c_init_y;
      r_dir_x      <= 1'b1;
      r_dir_y      <= 1'b1;
      bounce_count <= 8'h00;
    end else begin
      case (r_state)
        S_WAIT_FRAME: begin
          if (frame_tick && run) begin
            r_state <= S_UPDATE_X;
          end
        end
        S_UPDATE_X: begin
          r_state <= S_UPDATE_Y;
          if (r_dir_x) begin
            if (w_x_inc > c_x_max) begin
              box_x        <= c_x_max_10;
              r_dir_x      <= 1'b0;
              bounce_count <= bounce_count + 8'd1;
            end else begin
              box_x <= w_x_inc[9:0];
            end
          end else begin
            if (box_x < c_step_10) begin
              box_x        <= 10'd0;
              r_dir_x      <= 1'b1;
              bounce_count <= bounce_count + 8'd1;
            end else begin
              box_x <= box_x - c_step_10;
            end
          end
        end
        S_UPDATE_Y: begin
          r_state <= S_WAIT_FRAME;
          if (r_dir_y) begin
            if (w_y_inc > c_y_max) begin
              box_y        <= c_y_max_10;
              r_dir_y      <= 1'b0;
              bounce_count <= bounce_count + 8'd1;
            end else begin
              box_y <= w_y_inc[9:0];
            end
          end else begin
            if (box_y < c_step_10) begin
              box_y        <= 10'd0;
              r_dir_y      <= 1'b1;
              bounce_count <= bounce_count + 8'd1;
            end else begin
              box_y <= box_y - c_step_10;
            end
          end
        end
        default: begin
          r_state <= S_WAIT_FRAME;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
